// File: rtl/dino_game_fsm.sv
// ---------------------------------------------------------------------------
// dino_game_fsm
// Game-state controller for the T-rex game. It tracks UnBegin / Running /
// Dead / Paused, lives with a post-hit invulnerability window, a restart
// holdoff after death, a prescaled score tick and a high-score register.
// Jump and pause are edge detected, so holding a button gives one event.
//
// Ports
//   clk         system clock
//   rst         synchronous active-low reset
//   collision   level, obstacle overlap this cycle
//   jump        level, debounced jump button
//   pause       level, debounced pause button
//   gamestate   00 UnBegin, 01 Running, 10 Dead, 11 Paused
//   lives_left  remaining lives
//   invuln      high while the invulnerability counter is nonzero
//   score       current score (saturating)
//   hiscore     best score since reset
//   new_game    one-cycle pulse on entry to Running from UnBegin or Dead
// ---------------------------------------------------------------------------
module dino_game_fsm #(
   parameter int unsigned LIVES           = 3,
   parameter int unsigned LIFE_W          = 2,
   parameter int unsigned INVULN_CYCLES   = 50,
   parameter int unsigned RESTART_HOLDOFF = 100,
   parameter int unsigned SCORE_W         = 16,
   parameter int unsigned SCORE_DIV       = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               collision,
   input  logic               jump,
   input  logic               pause,
   output logic [1:0]         gamestate,
   output logic [LIFE_W-1:0]  lives_left,
   output logic               invuln,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hiscore,
   output logic               new_game
);

   localparam int unsigned INV_W  = $clog2(INVULN_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(RESTART_HOLDOFF + 1);
   localparam int unsigned PRE_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(SCORE_DIV - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      ST_UNBEGIN = 2'b00,
      ST_RUNNING = 2'b01,
      ST_DEAD    = 2'b10,
      ST_PAUSED  = 2'b11
   } state_e;

   state_e              state_q,      state_d;
   logic [LIFE_W-1:0]   lives_q,      lives_d;
   logic [INV_W-1:0]    invuln_cnt_q, invuln_cnt_d;
   logic                invuln_q,     invuln_d;
   logic [HOLD_W-1:0]   holdoff_q,    holdoff_d;
   logic [PRE_W-1:0]    prescale_q,   prescale_d;
   logic [SCORE_W-1:0]  score_q,      score_d;
   logic [SCORE_W-1:0]  hiscore_q,    hiscore_d;
   logic                new_game_q,   new_game_d;
   logic                jump_q;
   logic                pause_q;

   logic                jump_rise;
   logic                pause_rise;
   logic                start_game;
   logic                score_tick;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_UNBEGIN;
         lives_q      <= LIFE_W'(LIVES);
         invuln_cnt_q <= '0;
         invuln_q     <= 1'b0;
         holdoff_q    <= '0;
         prescale_q   <= '0;
         score_q      <= '0;
         hiscore_q    <= '0;
         new_game_q   <= 1'b0;
         jump_q       <= 1'b0;
         pause_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         invuln_cnt_q <= invuln_cnt_d;
         invuln_q     <= invuln_d;
         holdoff_q    <= holdoff_d;
         prescale_q   <= prescale_d;
         score_q      <= score_d;
         hiscore_q    <= hiscore_d;
         new_game_q   <= new_game_d;
         jump_q       <= jump;
         pause_q      <= pause;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      invuln_cnt_d = invuln_cnt_q;
      holdoff_d    = holdoff_q;
      prescale_d   = prescale_q;
      score_d      = score_q;
      hiscore_d    = hiscore_q;
      new_game_d   = 1'b0;
      start_game   = 1'b0;
      score_tick   = 1'b0;

      jump_rise  = jump & ~jump_q;
      pause_rise = pause & ~pause_q;

      case (state_q)
         ST_UNBEGIN: begin
            if (jump_rise) begin
               start_game = 1'b1;
            end
         end

         ST_RUNNING: begin
            if (invuln_cnt_q != '0) begin
               invuln_cnt_d = invuln_cnt_q - INV_W'(1);
            end
            if (collision && (invuln_cnt_q == '0)) begin
               if (lives_q > LIFE_W'(1)) begin
                  lives_d      = lives_q - LIFE_W'(1);
                  invuln_cnt_d = INV_W'(INVULN_CYCLES);
                  score_tick   = 1'b1;
               end else begin
                  // Fatal hit: score is frozen so hiscore captures what is shown
                  lives_d   = '0;
                  state_d   = ST_DEAD;
                  holdoff_d = HOLD_W'(RESTART_HOLDOFF);
                  hiscore_d = (score_q > hiscore_q) ? score_q : hiscore_q;
               end
            end else begin
               score_tick = 1'b1;
               if (pause_rise) begin
                  state_d = ST_PAUSED;
               end
            end
         end

         ST_PAUSED: begin
            if (pause_rise) begin
               state_d = ST_RUNNING;
            end
         end

         ST_DEAD: begin
            // A jump during holdoff is dropped, not remembered
            if (holdoff_q != '0) begin
               holdoff_d = holdoff_q - HOLD_W'(1);
            end else if (jump_rise) begin
               start_game = 1'b1;
            end
         end
      endcase

      // Prescaled, saturating score counter
      if (score_tick) begin
         if (prescale_q == PRE_LAST) begin
            prescale_d = '0;
            if (score_q != SCORE_MAX) begin
               score_d = score_q + SCORE_W'(1);
            end
         end else begin
            prescale_d = prescale_q + PRE_W'(1);
         end
      end

      // Fresh game from UnBegin or Dead; hiscore is kept
      if (start_game) begin
         state_d      = ST_RUNNING;
         lives_d      = LIFE_W'(LIVES);
         score_d      = '0;
         prescale_d   = '0;
         invuln_cnt_d = '0;
         holdoff_d    = '0;
         new_game_d   = 1'b1;
      end

      invuln_d = (invuln_cnt_d != '0);
   end

   assign gamestate  = state_q;
   assign lives_left = lives_q;
   assign invuln     = invuln_q;
   assign score      = score_q;
   assign hiscore    = hiscore_q;
   assign new_game   = new_game_q;

endmodule

// File: tb/tb_dino_game_fsm.sv
// ---------------------------------------------------------------------------
// tb_dino_game_fsm
// Directed bench for dino_game_fsm with LIVES=2, INVULN_CYCLES=4,
// RESTART_HOLDOFF=8, SCORE_DIV=4, SCORE_W=4. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_dino_game_fsm;

   logic       clk;
   logic       rst;
   logic       collision;
   logic       jump;
   logic       pause;
   logic [1:0] gamestate;
   logic [1:0] lives_left;
   logic       invuln;
   logic [3:0] score;
   logic [3:0] hiscore;
   logic       new_game;

   int n_cmp;
   int n_err;

   dino_game_fsm #(
      .LIVES          (2),
      .LIFE_W         (2),
      .INVULN_CYCLES  (4),
      .RESTART_HOLDOFF(8),
      .SCORE_W        (4),
      .SCORE_DIV      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .collision (collision),
      .jump      (jump),
      .pause     (pause),
      .gamestate (gamestate),
      .lives_left(lives_left),
      .invuln    (invuln),
      .score     (score),
      .hiscore   (hiscore),
      .new_game  (new_game)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      collision = 1'b0; jump = 1'b0; pause = 1'b0;
      rst = 1'b0;
      step(1);
      rst = 1'b1;
   endtask

   task automatic start_game();
      jump = 1'b1;
      step(1);
      jump = 1'b0;
   endtask

   task automatic test_reset();
      collision = 1'b0; jump = 1'b0; pause = 1'b0;
      rst = 1'b0;
      step(2);
      n_cmp++; if (gamestate !== 2'b00) begin n_err++; $display("FAIL rst_state got %0d exp 0", gamestate); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL rst_lives got %0d exp 2", lives_left); end
      n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL rst_invuln got %0d exp 0", invuln); end
      n_cmp++; if (score !== 4'd0) begin n_err++; $display("FAIL rst_score got %0d exp 0", score); end
      n_cmp++; if (hiscore !== 4'd0) begin n_err++; $display("FAIL rst_hiscore got %0d exp 0", hiscore); end
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL rst_new_game got %0d exp 0", new_game); end
      rst = 1'b1;
      // pause and collision do nothing in UnBegin
      pause = 1'b1; collision = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b00) begin n_err++; $display("FAIL unbegin_ignore got %0d exp 0", gamestate); end
      pause = 1'b0; collision = 1'b0;
      step(1);
   endtask

   task automatic test_start();
      jump = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL start_state got %0d exp 1", gamestate); end
      n_cmp++; if (new_game !== 1'b1) begin n_err++; $display("FAIL start_pulse got %0d exp 1", new_game); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL start_lives got %0d exp 2", lives_left); end
      step(1);
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL start_pulse_len got %0d exp 0", new_game); end
      step(8);
      jump = 1'b0;
      step(1);
      jump = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL run_jump_state got %0d exp 1", gamestate); end
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL run_jump_pulse got %0d exp 0", new_game); end
      jump = 1'b0;
   endtask

   task automatic test_score();
      do_reset();
      start_game();
      step(20);
      n_cmp++; if (score !== 4'd5) begin n_err++; $display("FAIL score_20 got %0d exp 5", score); end
      step(40);
      n_cmp++; if (score !== 4'd15) begin n_err++; $display("FAIL score_60 got %0d exp 15", score); end
      step(8);
      n_cmp++; if (score !== 4'd15) begin n_err++; $display("FAIL score_sat got %0d exp 15", score); end
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL score_state got %0d exp 1", gamestate); end
   endtask

   task automatic test_lives();
      do_reset();
      start_game();
      step(12);
      n_cmp++; if (score !== 4'd3) begin n_err++; $display("FAIL lives_pre_score got %0d exp 3", score); end
      collision = 1'b1;
      step(1);
      n_cmp++; if (lives_left !== 2'd1) begin n_err++; $display("FAIL hit_lives got %0d exp 1", lives_left); end
      n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL hit_invuln got %0d exp 1", invuln); end
      for (int i = 0; i < 3; i++) begin
         step(1);
         n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL invuln_win%0d got %0d exp 1", i, invuln); end
         n_cmp++; if (lives_left !== 2'd1) begin n_err++; $display("FAIL invuln_lives%0d got %0d exp 1", i, lives_left); end
      end
      step(1);
      n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL invuln_end got %0d exp 0", invuln); end
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL invuln_end_state got %0d exp 1", gamestate); end
      step(1);
      n_cmp++; if (gamestate !== 2'b10) begin n_err++; $display("FAIL death_state got %0d exp 2", gamestate); end
      n_cmp++; if (lives_left !== 2'd0) begin n_err++; $display("FAIL death_lives got %0d exp 0", lives_left); end
      n_cmp++; if (score !== 4'd4) begin n_err++; $display("FAIL death_score got %0d exp 4", score); end
      n_cmp++; if (hiscore !== 4'd4) begin n_err++; $display("FAIL death_hiscore got %0d exp 4", hiscore); end
      collision = 1'b0;
   endtask

   task automatic test_dead();
      step(2);
      jump = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b10) begin n_err++; $display("FAIL holdoff_jump got %0d exp 2", gamestate); end
      // held through holdoff expiry: no queued restart
      step(7);
      n_cmp++; if (gamestate !== 2'b10) begin n_err++; $display("FAIL holdoff_noqueue got %0d exp 2", gamestate); end
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL holdoff_pulse got %0d exp 0", new_game); end
      jump = 1'b0;
      step(1);
      jump = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL restart_state got %0d exp 1", gamestate); end
      n_cmp++; if (new_game !== 1'b1) begin n_err++; $display("FAIL restart_pulse got %0d exp 1", new_game); end
      n_cmp++; if (score !== 4'd0) begin n_err++; $display("FAIL restart_score got %0d exp 0", score); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL restart_lives got %0d exp 2", lives_left); end
      n_cmp++; if (hiscore !== 4'd4) begin n_err++; $display("FAIL restart_hiscore got %0d exp 4", hiscore); end
      jump = 1'b0;
      collision = 1'b1;
      step(6);
      n_cmp++; if (gamestate !== 2'b10) begin n_err++; $display("FAIL death2_state got %0d exp 2", gamestate); end
      n_cmp++; if (score !== 4'd1) begin n_err++; $display("FAIL death2_score got %0d exp 1", score); end
      n_cmp++; if (hiscore !== 4'd4) begin n_err++; $display("FAIL death2_hiscore got %0d exp 4", hiscore); end
      collision = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      n_cmp++; if (gamestate !== 2'b00) begin n_err++; $display("FAIL rst_dead_state got %0d exp 0", gamestate); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL rst_dead_lives got %0d exp 2", lives_left); end
      n_cmp++; if (score !== 4'd0) begin n_err++; $display("FAIL rst_dead_score got %0d exp 0", score); end
      n_cmp++; if (hiscore !== 4'd0) begin n_err++; $display("FAIL rst_dead_hiscore got %0d exp 0", hiscore); end
      n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL rst_dead_invuln got %0d exp 0", invuln); end
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL rst_dead_pulse got %0d exp 0", new_game); end
      rst = 1'b1;
   endtask

   task automatic test_pause();
      do_reset();
      start_game();
      step(12);
      pause = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b11) begin n_err++; $display("FAIL pause_state got %0d exp 3", gamestate); end
      n_cmp++; if (score !== 4'd3) begin n_err++; $display("FAIL pause_score got %0d exp 3", score); end
      collision = 1'b1; jump = 1'b1;
      step(10);
      n_cmp++; if (gamestate !== 2'b11) begin n_err++; $display("FAIL paused_hold got %0d exp 3", gamestate); end
      n_cmp++; if (score !== 4'd3) begin n_err++; $display("FAIL paused_score got %0d exp 3", score); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL paused_lives got %0d exp 2", lives_left); end
      n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL paused_invuln got %0d exp 0", invuln); end
      collision = 1'b0; jump = 1'b0; pause = 1'b0;
      step(1);
      pause = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL resume_state got %0d exp 1", gamestate); end
      pause = 1'b0;
      step(2);
      n_cmp++; if (score !== 4'd3) begin n_err++; $display("FAIL resume_score_a got %0d exp 3", score); end
      step(1);
      n_cmp++; if (score !== 4'd4) begin n_err++; $display("FAIL resume_score_b got %0d exp 4", score); end
   endtask

   task automatic test_collide_pause();
      collision = 1'b1; pause = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b01) begin n_err++; $display("FAIL prio_state got %0d exp 1", gamestate); end
      n_cmp++; if (lives_left !== 2'd1) begin n_err++; $display("FAIL prio_lives got %0d exp 1", lives_left); end
      n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL prio_invuln got %0d exp 1", invuln); end
      collision = 1'b0; pause = 1'b0;
      step(1);
   endtask

   task automatic test_reset_paused();
      pause = 1'b1;
      step(1);
      n_cmp++; if (gamestate !== 2'b11) begin n_err++; $display("FAIL pre_rst_pause got %0d exp 3", gamestate); end
      pause = 1'b0;
      rst = 1'b0;
      step(1);
      n_cmp++; if (gamestate !== 2'b00) begin n_err++; $display("FAIL rst_pause_state got %0d exp 0", gamestate); end
      n_cmp++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL rst_pause_lives got %0d exp 2", lives_left); end
      n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL rst_pause_invuln got %0d exp 0", invuln); end
      n_cmp++; if (score !== 4'd0) begin n_err++; $display("FAIL rst_pause_score got %0d exp 0", score); end
      n_cmp++; if (hiscore !== 4'd0) begin n_err++; $display("FAIL rst_pause_hiscore got %0d exp 0", hiscore); end
      n_cmp++; if (new_game !== 1'b0) begin n_err++; $display("FAIL rst_pause_pulse got %0d exp 0", new_game); end
      rst = 1'b1;
      step(1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0; collision = 1'b0; jump = 1'b0; pause = 1'b0;
      test_reset();
      test_start();
      test_score();
      test_lives();
      test_dead();
      test_pause();
      test_collide_pause();
      test_reset_paused();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
